// File: rtl/conv_pkg.sv
// Shared definitions for the convolution / max-pool engine.
// Contents:
//   state_t        - engine FSM states (IDLE, MAC, DONE)
//   LOAD_SEL_*     - load_sel encodings choosing the destination shift bank
//   acc_width()    - accumulator width that cannot overflow for a full window
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic LOAD_SEL_ACT    = 1'b0;
    localparam logic LOAD_SEL_WEIGHT = 1'b1;

    // Sum of taps full-width products: 2*data_w bits each, plus log2(taps)
    // bits of growth from adding taps of them together.
    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/conv_maxpool_engine_if.sv
// Load / control / result bundle of the convolution / max-pool engine.
// master: drives load_valid, load_sel, load_data, signed_mode, start,
//         clear_max; observes load_ready, busy, result_valid, result,
//         max_out, max_idx, max_valid.
// slave : the engine side, opposite directions.
interface conv_maxpool_engine_if #(
    parameter int DATA_W = 6,
    parameter int TAPS   = 4,
    parameter int IDX_W  = 8
);
    import conv_pkg::*;

    localparam int ACC_W = acc_width(DATA_W, TAPS);

    logic              load_valid;
    logic              load_sel;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              signed_mode;
    logic              start;
    logic              clear_max;
    logic              busy;
    logic              result_valid;
    logic [ACC_W-1:0]  result;
    logic [ACC_W-1:0]  max_out;
    logic [IDX_W-1:0]  max_idx;
    logic              max_valid;

    modport master (
        output load_valid, load_sel, load_data, signed_mode, start, clear_max,
        input  load_ready, busy, result_valid, result, max_out, max_idx, max_valid
    );

    modport slave (
        input  load_valid, load_sel, load_data, signed_mode, start, clear_max,
        output load_ready, busy, result_valid, result, max_out, max_idx, max_valid
    );

endinterface

// File: rtl/mac_unit.sv
// One multiply-accumulate step: acc_out = acc_in + act * weight.
// Ports:
//   signed_mode - treat act/weight as two's complement when 1
//   act, weight - DATA_W operands
//   acc_in      - current accumulator (ACC_W)
//   acc_out     - accumulator plus the extended product (ACC_W)
module mac_unit #(
    parameter int DATA_W = 6,
    parameter int ACC_W  = 14
) (
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] weight,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out
);
    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] prod_u;
    logic [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]  prod_ext;

    // Operands are widened to the full product width first, so the low
    // PROD_W bits of each product are exact for its interpretation.
    always_comb begin
        prod_u   = {{DATA_W{1'b0}}, act} * {{DATA_W{1'b0}}, weight};
        prod_s   = $signed({{DATA_W{act[DATA_W-1]}}, act})
                 * $signed({{DATA_W{weight[DATA_W-1]}}, weight});
        prod_ext = signed_mode ? {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s}
                               : {{(ACC_W-PROD_W){1'b0}}, prod_u};
        acc_out  = acc_in + prod_ext;
    end

endmodule

// File: rtl/conv_maxpool_engine.sv
// Serial-load dot-product engine with running max-pool tracking.
// Weights and activations are loaded one element at a time into two shift
// banks; a start pulse runs a TAPS-cycle sequential MAC, presents the
// result for one cycle and folds it into the running maximum.
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - conv_maxpool_engine_if.slave (load, control, results)
module conv_maxpool_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int TAPS   = 4,
    parameter int IDX_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv_maxpool_engine_if.slave   bus
);
    localparam int ACC_W = acc_width(DATA_W, TAPS);
    localparam int TAP_W = $clog2(TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    state_t            state;
    logic [DATA_W-1:0] weights [TAPS];
    logic [DATA_W-1:0] acts    [TAPS];
    logic [TAP_W-1:0]  tap;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  result_q;
    logic [ACC_W-1:0]  max_q;
    logic [IDX_W-1:0]  max_idx_q;
    logic [IDX_W-1:0]  win_cnt;
    logic              mode_q;
    logic              result_valid_q;
    logic              load_ready_q;
    logic              busy_q;
    logic              max_valid_q;
    logic              load_fire;
    logic              greater;
    logic              take_max;

    assign load_fire = bus.load_valid & load_ready_q;

    // Both banks shift toward slot 0, so the first element loaded ends up
    // in slot 0 after TAPS loads; only the selected bank moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                weights[k] <= '0;
                acts[k]    <= '0;
            end
        end else if (load_fire) begin
            if (bus.load_sel == LOAD_SEL_WEIGHT) begin
                for (int k = 0; k < TAPS - 1; k++) weights[k] <= weights[k+1];
                weights[TAPS-1] <= bus.load_data;
            end else begin
                for (int k = 0; k < TAPS - 1; k++) acts[k] <= acts[k+1];
                acts[TAPS-1] <= bus.load_data;
            end
        end
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .signed_mode (mode_q),
        .act         (acts[tap]),
        .weight      (weights[tap]),
        .acc_in      (acc),
        .acc_out     (acc_next)
    );

    // A clear arriving together with DONE wipes the old max first, so the
    // finishing window always becomes the new max in that case.
    always_comb begin
        greater  = mode_q ? ($signed(result_q) > $signed(max_q)) : (result_q > max_q);
        take_max = bus.clear_max | ~max_valid_q | greater;
    end

    // The result is registered on the last MAC edge so it is valid during
    // the whole DONE cycle; the max-pool update happens on the DONE edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            tap            <= '0;
            acc            <= '0;
            mode_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            load_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
            max_q          <= '0;
            max_idx_q      <= '0;
            max_valid_q    <= 1'b0;
            win_cnt        <= '0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= MAC;
                        acc          <= '0;
                        tap          <= '0;
                        mode_q       <= bus.signed_mode;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    tap <= tap + TAP_W'(1);
                    if (tap == LAST_TAP) begin
                        result_q       <= acc_next;
                        result_valid_q <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (state == DONE) begin
                if (take_max) begin
                    max_q       <= result_q;
                    max_idx_q   <= bus.clear_max ? '0 : win_cnt;
                    max_valid_q <= 1'b1;
                end
                win_cnt <= bus.clear_max ? IDX_W'(1) : win_cnt + IDX_W'(1);
            end else if (bus.clear_max) begin
                max_q       <= '0;
                max_idx_q   <= '0;
                max_valid_q <= 1'b0;
                win_cnt     <= '0;
            end
        end
    end

    assign bus.load_ready   = load_ready_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.max_out      = max_q;
    assign bus.max_idx      = max_idx_q;
    assign bus.max_valid    = max_valid_q;

endmodule

// File: tb/tb_conv_maxpool_engine.sv
// Scoreboard bench for conv_maxpool_engine: the stimulus side computes each
// window's dot product and max-pool state with plain integer arithmetic and
// queues it; an independent monitor checks every result_valid pulse and the
// max-pool outputs one cycle later.
module tb_conv_maxpool_engine;
    import conv_pkg::*;

    localparam int DATA_W = 6;
    localparam int TAPS   = 4;
    localparam int IDX_W  = 2;
    localparam int ACC_W  = acc_width(DATA_W, TAPS);

    typedef struct {
        logic [ACC_W-1:0] res;
        int               start_cyc;
        logic [ACC_W-1:0] mx;
        logic [IDX_W-1:0] mi;
        logic             mv;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    logic [DATA_W-1:0] m_act [TAPS];
    logic [DATA_W-1:0] m_wt  [TAPS];
    logic [ACC_W-1:0]  m_max;
    logic [IDX_W-1:0]  m_idx;
    logic              m_valid;
    int                m_cnt;

    conv_maxpool_engine_if #(.DATA_W(DATA_W), .TAPS(TAPS), .IDX_W(IDX_W)) bus ();

    conv_maxpool_engine #(.DATA_W(DATA_W), .TAPS(TAPS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input longint actual, input longint expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic longint to_val(input logic [DATA_W-1:0] x, input bit sgn);
        longint v = longint'(x);
        if (sgn && x[DATA_W-1]) v -= (longint'(1) << DATA_W);
        return v;
    endfunction

    function automatic longint acc_val(input logic [ACC_W-1:0] x, input bit sgn);
        longint v = longint'(x);
        if (sgn && x[ACC_W-1]) v -= (longint'(1) << ACC_W);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_act[i] = '0;
            m_wt[i]  = '0;
        end
        m_max = '0; m_idx = '0; m_valid = 1'b0; m_cnt = 0;
    endfunction

    function automatic void model_clear();
        m_max = '0; m_idx = '0; m_valid = 1'b0; m_cnt = 0;
    endfunction

    // Expected outcome of one window: exact dot product, then max-pool rules.
    function automatic void model_window(input bit mode, input bit clr_done, input int start_cyc);
        longint dot = 0;
        exp_t   e;
        for (int i = 0; i < TAPS; i++) dot += to_val(m_act[i], mode) * to_val(m_wt[i], mode);
        e.res = dot[ACC_W-1:0];
        if (clr_done) model_clear();
        if (!m_valid || dot > acc_val(m_max, mode)) begin
            m_max   = e.res;
            m_idx   = IDX_W'(m_cnt);
            m_valid = 1'b1;
        end
        m_cnt = (m_cnt + 1) % (1 << IDX_W);
        e.start_cyc = start_cyc;
        e.mx = m_max;
        e.mi = m_idx;
        e.mv = m_valid;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid  = 1'b0;
        bus.load_sel    = 1'b0;
        bus.load_data   = '0;
        bus.start       = 1'b0;
        bus.clear_max   = 1'b0;
        bus.signed_mode = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic load_elem(input logic sel, input logic [DATA_W-1:0] data);
        bus.load_valid = 1'b1;
        bus.load_sel   = sel;
        bus.load_data  = data;
        tick();
        bus.load_valid = 1'b0;
        if (sel == LOAD_SEL_WEIGHT) begin
            for (int i = 0; i < TAPS - 1; i++) m_wt[i] = m_wt[i+1];
            m_wt[TAPS-1] = data;
        end else begin
            for (int i = 0; i < TAPS - 1; i++) m_act[i] = m_act[i+1];
            m_act[TAPS-1] = data;
        end
    endtask

    task automatic apply_stimulus(input logic [DATA_W-1:0] a [TAPS], input logic [DATA_W-1:0] w [TAPS]);
        for (int i = 0; i < TAPS; i++) load_elem(LOAD_SEL_ACT, a[i]);
        for (int i = 0; i < TAPS; i++) load_elem(LOAD_SEL_WEIGHT, w[i]);
    endtask

    task automatic clear_alone();
        bus.clear_max = 1'b1;
        tick();
        bus.clear_max = 1'b0;
        model_clear();
        check_output("clear_max_valid", bus.max_valid, 0);
        check_output("clear_max_out", bus.max_out, 0);
    endtask

    // Start one window; optionally hammer start/load during busy and
    // optionally assert clear_max in the DONE cycle.
    task automatic run_window(input bit mode, input bit clr_done, input bit noise);
        model_window(mode, clr_done, cyc);
        bus.signed_mode = mode;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.signed_mode = 1'($urandom);
        for (int i = 0; i <= TAPS; i++) begin
            if (i == 0) begin
                check_output("busy_in_mac", bus.busy, 1);
                check_output("load_ready_in_mac", bus.load_ready, 0);
            end
            if (noise) begin
                bus.start      = 1'($urandom);
                bus.load_valid = 1'($urandom);
                bus.load_sel   = 1'($urandom);
                bus.load_data  = DATA_W'($urandom);
            end
            if (i == TAPS && clr_done) bus.clear_max = 1'b1;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    // Monitor: checks result and latency on result_valid, max state one cycle later.
    initial begin
        exp_t cur;
        bit   pend_max;
        pend_max = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_max = 1'b0;
            end else begin
                if (pend_max) begin
                    check_output("max_out", bus.max_out, cur.mx);
                    check_output("max_idx", bus.max_idx, cur.mi);
                    check_output("max_valid", bus.max_valid, cur.mv);
                    pend_max = 1'b0;
                end
                if (bus.result_valid) begin
                    if (exp_q.size() == 0) begin
                        check_output("spurious_result_valid", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check_output("result", bus.result, cur.res);
                        check_output("latency", cyc - cur.start_cyc, TAPS + 1);
                        pend_max = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] a [TAPS];
        logic [DATA_W-1:0] w [TAPS];
        bit mode;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        idle_inputs();
        do_reset();

        check_output("rst_result", bus.result, 0);
        check_output("rst_result_valid", bus.result_valid, 0);
        check_output("rst_max_out", bus.max_out, 0);
        check_output("rst_max_idx", bus.max_idx, 0);
        check_output("rst_max_valid", bus.max_valid, 0);
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_load_ready", bus.load_ready, 1);

        // Basic unsigned window: 1*4 + 2*3 + 3*2 + 4*1 = 20.
        a = '{6'd1, 6'd2, 6'd3, 6'd4};
        w = '{6'd4, 6'd3, 6'd2, 6'd1};
        apply_stimulus(a, w);
        run_window(1'b0, 1'b0, 1'b0);

        // Max tracking: 15876, 100, then a tie at 15876 keeps index 1.
        a = '{6'd63, 6'd63, 6'd63, 6'd63};
        apply_stimulus(a, a);
        run_window(1'b0, 1'b0, 1'b0);
        a = '{6'd10, 6'd0, 6'd0, 6'd0};
        apply_stimulus(a, a);
        run_window(1'b0, 1'b0, 1'b0);
        a = '{6'd63, 6'd63, 6'd63, 6'd63};
        apply_stimulus(a, a);
        run_window(1'b0, 1'b0, 1'b0);

        // Signed: -32 * 31 * 4 = -3968, then -32 * -32 * 4 = 4096.
        clear_alone();
        a = '{6'h20, 6'h20, 6'h20, 6'h20};
        w = '{6'd31, 6'd31, 6'd31, 6'd31};
        apply_stimulus(a, w);
        run_window(1'b1, 1'b0, 1'b0);
        clear_alone();
        apply_stimulus(a, a);
        run_window(1'b1, 1'b0, 1'b0);

        // Protocol: start/load noise while busy, clear_max in the DONE cycle.
        a = '{6'd1, 6'd2, 6'd3, 6'd4};
        w = '{6'd4, 6'd3, 6'd2, 6'd1};
        apply_stimulus(a, w);
        run_window(1'b0, 1'b0, 1'b1);
        run_window(1'b0, 1'b1, 1'b1);

        // Reset during the second MAC cycle: no result, clean restart.
        a = '{6'd5, 6'd6, 6'd7, 6'd8};
        apply_stimulus(a, a);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        model_reset();
        check_output("midrst_busy", bus.busy, 0);
        check_output("midrst_result", bus.result, 0);
        check_output("midrst_max_out", bus.max_out, 0);
        check_output("midrst_max_valid", bus.max_valid, 0);
        check_output("midrst_load_ready", bus.load_ready, 1);
        rst_n = 1'b1;
        tick();
        apply_stimulus(a, a);
        run_window(1'b0, 1'b0, 1'b0);

        // Window counter wrap: five increasing results give idx 0,1,2,3,0.
        clear_alone();
        w = '{6'd1, 6'd0, 6'd0, 6'd0};
        for (int k = 1; k <= 5; k++) begin
            a = '{DATA_W'(k), 6'd0, 6'd0, 6'd0};
            apply_stimulus(a, w);
            run_window(1'b0, 1'b0, 1'b0);
        end

        // Randomised windows, grouped by mode with a clear between groups.
        for (int g = 0; g < 6; g++) begin
            mode = 1'($urandom);
            clear_alone();
            for (int n = 0; n < 5; n++) begin
                for (int i = 0; i < TAPS; i++) begin
                    a[i] = DATA_W'($urandom);
                    w[i] = DATA_W'($urandom);
                end
                apply_stimulus(a, w);
                run_window(mode, ($urandom_range(0, 5) == 0), 1'($urandom));
            end
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
        check_output("drain_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
